imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write side of the instruction memory: receives a program as a byte stream and writes 32-bit words into imem.
//  Holds the CPU (PC/fetch) in hold until a complete, length-checked image is in memory, then releases it.
//  Sits between a host byte source (UART/bench driver) and the instruction memory write port.
// PARAMETERS
//  ADDR_W     8    imem word-address width; capacity = 2**ADDR_W words
//  DATA_W     32   instruction word width; fixed, 4 bytes per word
// PORTS
//  clk           in   1        system clock, rising edge
//  rst           in   1        synchronous, active-high reset
//  start         in   1        1-cycle pulse: begin (or restart) a load
//  byte_in       in   8        stream byte
//  byte_valid    in   1        byte_in valid
//  byte_ready    out  1        loader accepts byte; transfer = valid & ready at rising clk
//  mem_we        out  1        imem write strobe, 1 cycle per word
//  mem_addr      out  ADDR_W   imem word index
//  mem_wdata     out  32       instruction word
//  words_loaded  out  ADDR_W+1 payload words written so far
//  cpu_hold      out  1        1 = CPU held, PC must not advance
//  done          out  1        image loaded and valid; sticky until start/rst
//  err           out  1        load failed; sticky until start/rst
// BEHAVIOUR
//  - Reset, synchronous: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0, cpu_hold=1, done=0, err=0.
//  - Image format: 4-byte header N (word count), then N payload words. All words big-endian, first byte -> bits[31:24].
//  - Each state is entered on the clock edge after its condition.
//  - IDLE: byte_ready=0. start -> HDR; clears counters, done and err; cpu_hold=1.
//  - HDR: byte_ready=1; packs 4 bytes into N.
//      N==0 -> DONE. N>2**ADDR_W -> ERR. Otherwise -> LOAD.
//  - LOAD: byte_ready=1; packs 4 bytes per word.
//      mem_we pulses high for exactly 1 cycle, in the cycle after the edge that accepted the 4th byte, with
//      mem_addr = word index (first word at 0) and mem_wdata = packed word.
//      The first word is index 0 because the PC starts at 0 after reset.
//      words_loaded increments on the same edge. After word N-1 -> DONE (or CHK, see CONFIGURATION).
//  - byte_valid low mid-word: partial word is kept; packing has no timeout.
//  - DONE: byte_ready=0, done=1, cpu_hold=0. The cycle of mem_we for the last word precedes cpu_hold falling.
//  - ERR: byte_ready=0, err=1, cpu_hold=1; bytes are ignored. Only start or rst leaves ERR.
//  - start in any state, including mid-word in HDR/LOAD: aborts and re-enters HDR; the partial word is discarded.
//      Memory already written is not cleared.
//  - start and byte_valid in the same cycle: the byte is not accepted.
//  - rst mid-load: full reset values; cpu_hold=1. The memory image is undefined until a new load completes.
//  - Address wrap: impossible by the N bound. N == 2**ADDR_W fills memory exactly, with the last mem_addr = all ones.
//  - All outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  - IMEM_LOADER_CHECKSUM_EN defined:
//      After N payload words, state CHK accepts one more 4-byte word C (not written to memory).
//      C == XOR of all payload words -> DONE; otherwise -> ERR.
//      With N==0, HDR -> CHK and the expected C is 0.
//  - Macro undefined: no CHK state. The last payload word goes straight to DONE; no trailing word is expected.
// STRUCTURE
//  - Shared package mips_pkg:
//      loader state encoding (IDLE, HDR, LOAD, CHK, DONE, ERR)
//      BYTES_PER_WORD=4
//      IMEM_ADDR_W default
//      instruction width constant 32
//  - Sub-module byte_word_packer:
//      byte counter 0..3 and big-endian shift register
//      outputs word_valid pulse + word; clear input driven by start/rst
//  - imem_loader holds the FSM, counters, write-port registers and the optional XOR accumulator.
// TESTING
//  - Reset: assert rst 2 cycles.
//      -> cpu_hold=1, done=0, err=0, byte_ready=0, mem_we=0.
//  - Basic load: start; bytes 00 00 00 02, 20 08 00 05, 01 09 50 20.
//      -> mem_we at addr 0 data 0x20080005, then addr 1 data 0x01095020.
//      -> done=1, cpu_hold=0, words_loaded=2.
//  - Empty image: start; header 00 00 00 00.
//      -> DONE with no mem_we; cpu_hold=0.
//      -> with IMEM_LOADER_CHECKSUM_EN, expects C=00000000 first.
//  - Oversize: ADDR_W=8, header 00 00 01 01 (257).
//      -> err=1, cpu_hold=1, no mem_we; later bytes ignored; start recovers.
//  - Abort/stall: gaps in byte_valid inside a word, then start after 2 bytes of word 1.
//      -> no write of the partial word.
//      -> a reload of 1 word writes addr 0 and reaches done.
//  - Checksum (macro defined): 2 words 0x0000FFFF, 0x00FF00FF.
//      -> trailer 0x00FFFF00 gives done=1.
//      -> trailer 0x00000000 gives err=1 with cpu_hold=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the instruction-memory load path: word geometry,
// default imem depth and the loader state encoding.
package mips_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_ADDR_W    = 8;
  localparam int INSTR_W        = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_CHK  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  // States in which the loader consumes stream bytes.
  function automatic logic is_rx_state(input logic [2:0] s);
    return (s == ST_HDR) || (s == ST_LOAD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Big-endian byte-to-word packer. The first byte of a word lands in the
// top byte. word_valid/word are combinational from the accepting byte so the
// loader can register the finished word on the same edge that takes byte 4.
module byte_word_packer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               take,
  input  logic [7:0]         byte_in,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0]   cnt;
  logic [INSTR_W-9:0] shreg;

  // Byte counter and shift register; clear drops any partial word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (take) begin
      cnt   <= cnt + 1'b1;
      shreg <= {shreg[INSTR_W-17:0], byte_in};
    end
  end

  assign word_valid = take && (cnt == LAST_BYTE);
  assign word       = {shreg, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives "N, then N big-endian words" over a
// byte stream, writes them to imem from address 0, and holds the CPU until
// the whole image is in place.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// XOR-of-payload word before the image is accepted.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | after reset, waiting for start
// ST_HDR    | packing the 4-byte word count N
// ST_LOAD   | packing payload words and writing them to imem
// ST_CHK    | packing checksum word (checksum build only)
// ST_DONE   | image accepted, CPU released
// ST_ERR    | oversize header or bad checksum, CPU held
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [DATA_W-1:0] MAX_WORDS = DATA_W'(1) << ADDR_W;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W:0]   n_words;
  logic              take;
  logic              word_valid;
  logic [DATA_W-1:0] word;
  logic              last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] xor_acc;
`endif

  // A byte that arrives together with start belongs to no image.
  assign take      = byte_valid && byte_ready && !start;
  assign last_word = (words_loaded + (ADDR_W+1)'(1)) == n_words;

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .take       (take),
    .byte_in    (byte_in),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state decode; start wins from every state.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_HDR;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_HDR: begin
          if (word_valid) begin
            if (word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_nxt = ST_CHK;
`else
              state_nxt = ST_DONE;
`endif
            end else if (word > MAX_WORDS) begin
              state_nxt = ST_ERR;
            end else begin
              state_nxt = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (word_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = ST_CHK;
`else
            state_nxt = ST_DONE;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (word_valid) state_nxt = (word == xor_acc) ? ST_DONE : ST_ERR;
        end
`endif
        ST_DONE: state_nxt = ST_DONE;
        ST_ERR:  state_nxt = ST_ERR;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, status flags, counters and the imem write-port registers.
  // done/cpu_hold follow the DONE state one cycle late so the last mem_we
  // is seen while the CPU is still held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      n_words      <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_ready <= is_rx_state(state_nxt);
      err        <= (state_nxt == ST_ERR);
      done       <= !start && (state == ST_DONE);
      cpu_hold   <= !(!start && (state == ST_DONE));
      mem_we     <= 1'b0;
      if (start) begin
        words_loaded <= '0;
        n_words      <= '0;
      end else if (state == ST_HDR && word_valid) begin
        n_words <= word[ADDR_W:0];
      end else if (state == ST_LOAD && word_valid) begin
        mem_we       <= 1'b1;
        mem_addr     <= words_loaded[ADDR_W-1:0];
        mem_wdata    <= word;
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of payload words, compared against the trailer in CHK.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      xor_acc <= '0;
    end else if (state == ST_LOAD && word_valid) begin
      xor_acc <= xor_acc ^ word;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte timing and images,
// checked against expectations derived from the image format.
// Honours IMEM_LOADER_CHECKSUM_EN when the design is built with it.
module tb_imem_loader;

  typedef logic [31:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  words_loaded;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic        wr_hold_q[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .words_loaded (words_loaded),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err)
  );

  // Capture every imem write, away from the active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_hold_q.push_back(cpu_hold);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_hold_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One byte with a random idle gap before it; waits (bounded) for ready.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    guard      = 0;
    while (!byte_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!byte_ready) begin
      chk("ready_timeout", 64'(byte_ready), 64'd1);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_end(input string tag);
    int k;
    for (k = 0; k < 200 && !(done || err); k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({tag, "_finished"}, 64'(done || err), 64'd1);
  endtask

  function automatic logic [31:0] xor_of(input wq_t p);
    logic [31:0] x = 32'h0;
    foreach (p[i]) x = x ^ p[i];
    return x;
  endfunction

  // Full load of an image; expectations come from the format rules alone.
  task automatic do_load(input string tag, input logic [31:0] n, input wq_t payload,
                         input logic [31:0] trailer);
    logic exp_ok;
    logic fits;
    int   exp_writes;
    clear_log();
    pulse_start();
    send_word(n);
    fits = (n <= 32'd256);
    if (fits) begin
      foreach (payload[i]) send_word(payload[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(trailer);
`endif
    end
    wait_end(tag);
    exp_ok = fits;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (trailer != xor_of(payload)) exp_ok = 1'b0;
`endif
    exp_writes = fits ? int'(n) : 0;
    chk({tag, "_done"}, 64'(done), 64'(exp_ok));
    chk({tag, "_err"}, 64'(err), 64'(!exp_ok));
    chk({tag, "_hold"}, 64'(cpu_hold), 64'(!exp_ok));
    chk({tag, "_ready"}, 64'(byte_ready), 64'd0);
    chk({tag, "_wl"}, 64'(words_loaded), 64'(exp_writes));
    chk({tag, "_nwr"}, 64'(wr_addr_q.size()), 64'(exp_writes));
    if (wr_addr_q.size() == exp_writes) begin
      for (int i = 0; i < exp_writes; i++) begin
        chk($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_q[i]), 64'(i));
        chk($sformatf("%s_data%0d", tag, i), 64'(wr_data_q[i]), 64'(payload[i]));
      end
      if (exp_writes > 0)
        chk({tag, "_hold_at_last_we"}, 64'(wr_hold_q[exp_writes-1]), 64'd1);
    end
  endtask

  wq_t         p;
  logic [31:0] n;
  logic [31:0] w0, wr;

  initial begin
    rst = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ready", 64'(byte_ready), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_wl", 64'(words_loaded), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ready", 64'(byte_ready), 64'd0);

    // Basic two-word program.
    p = '{32'h20080005, 32'h01095020};
    do_load("basic", 32'd2, p, xor_of(p));

    // Empty image.
    p = {};
    do_load("empty", 32'd0, p, 32'h0);

    // Oversize header: error, later bytes ignored, start recovers.
    do_load("over", 32'd257, p, 32'h0);
    clear_log();
    @(negedge clk);
    byte_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("over_ignore_nwr", 64'(wr_addr_q.size()), 64'd0);
    chk("over_ignore_err", 64'(err), 64'd1);
    chk("over_ignore_hold", 64'(cpu_hold), 64'd1);
    do_load("over_big", 32'h01000000, p, 32'h0);
    p = '{32'hDEADBEEF};
    do_load("recover", 32'd1, p, xor_of(p));

    // Abort after two bytes of word 1; a byte coincident with start is dropped.
    clear_log();
    w0 = $urandom;
    wr = $urandom;
    pulse_start();
    send_word(32'd2);
    send_word(w0);
    send_byte(8'hA5);
    send_byte(8'h5A);
    @(negedge clk);
    start = 1'b1; byte_valid = 1'b1; byte_in = 8'hFF;
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0;
    chk("abort_hold", 64'(cpu_hold), 64'd1);
    send_word(32'd1);
    send_word(wr);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(wr);
`endif
    wait_end("abort");
    chk("abort_done", 64'(done), 64'd1);
    chk("abort_wl", 64'(words_loaded), 64'd1);
    chk("abort_nwr", 64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) begin
      chk("abort_a0", 64'(wr_addr_q[0]), 64'd0);
      chk("abort_d0", 64'(wr_data_q[0]), 64'(w0));
      chk("abort_a1", 64'(wr_addr_q[1]), 64'd0);
      chk("abort_d1", 64'(wr_data_q[1]), 64'(wr));
    end

    // Reset in the middle of a load.
    pulse_start();
    send_word(32'd3);
    send_word($urandom);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_hold", 64'(cpu_hold), 64'd1);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_ready", 64'(byte_ready), 64'd0);
    chk("mrst_wl", 64'(words_loaded), 64'd0);
    rst = 1'b0;

    // Random images, including random bad trailers in the checksum build.
    for (int t = 0; t < 6; t++) begin
      n = 32'($urandom_range(1, 8));
      p = {};
      for (int i = 0; i < int'(n); i++) p.push_back($urandom);
      do_load($sformatf("rnd%0d", t), n, p,
              ($urandom_range(0, 1) == 0) ? xor_of(p) : 32'($urandom));
    end

    // Exact fill: 256 words, last address all ones.
    p = {};
    for (int i = 0; i < 256; i++) p.push_back($urandom);
    do_load("full", 32'd256, p, xor_of(p));

`ifdef IMEM_LOADER_CHECKSUM_EN
    p = '{32'h0000FFFF, 32'h00FF00FF};
    do_load("cks_good", 32'd2, p, 32'h00FFFF00);
    chk("cks_good_flag", 64'(done), 64'd1);
    do_load("cks_bad", 32'd2, p, 32'h00000000);
    chk("cks_bad_flag", 64'(err), 64'd1);
    p = {};
    do_load("cks_empty_bad", 32'd0, p, 32'h00000001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
